serial_negate_multi: RTL and testbench
======================================

// Module: serial_negate_multi
// PURPOSE
//  Bit-serial, LSB-first conditional two's-complement unit for the serial-parallel multiplier datapath.
//  Handles CHANNELS independent serial lanes sharing one word framing.
//  Each lane is negated or passed per word, selected at word start, and raises a flag on a negation overflow.
//  Sits between operand serialisers and the SPM adder chain, e.g. for sign-magnitude to two's-complement conversion.
// PARAMETERS
//  WIDTH     8   bits per serial word (>=2); bit WIDTH-1 is the sign bit
//  CHANNELS  1   number of parallel serial lanes (>=1)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         reset, synchronous, active-low
//  in_valid   in   1         a[] carries a valid bit this cycle; gaps (in_valid=0) allowed anywhere
//  start      in   1         qualified by in_valid; this bit is bit 0 (LSB) of a new word
//  neg        in   CHANNELS  per-lane negate select; sampled only on an accepted start bit
//  a          in   CHANNELS  serial input bit per lane
//  out_valid  out  1         out_bits valid this cycle
//  out_bits   out  CHANNELS  serial result bit per lane
//  out_first  out  1         out_bits is bit 0 of a word
//  out_last   out  1         out_bits is bit WIDTH-1 of a word
//  ovf        out  CHANNELS  per-lane overflow; meaningful only when out_last=1, else 0
//  busy       out  1         a word is in progress (state RUN)
//  frame_err  out  1         one-cycle pulse: a word was aborted, or a stray bit was dropped
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state IDLE, bit_cnt=0, neg_q=0, seen=0, and every output = 0.
//  Per-lane algorithm: copy bits up to and including the first 1, then invert the remaining bits.
//   - Result bit r = a ^ (neg_q & seen).
//   - On each accepted bit: seen <= seen | a.
//   - On an accepted start bit, seen and neg_q restart: r = a and seen <= a, with neg_q <= neg.
//  Latency: fixed 1 cycle. A bit accepted at edge t appears on out_* from t until t+1.
//   - out_valid = in_valid delayed by 1; gaps propagate unchanged.
//  States: IDLE, RUN.
//   - IDLE: in_valid & start -> RUN, bit_cnt <= 1.
//   - IDLE: in_valid & !start -> bit dropped, out_valid stays 0, frame_err pulses, stays IDLE.
//   - RUN: in_valid & !start -> bit_cnt++.
//   - RUN: on bit WIDTH-1 -> out_last=1 on output, bit_cnt <= 0, -> IDLE.
//   - RUN: in_valid & start (mid-word) -> current word aborted, frame_err pulses.
//     The start bit is then processed as bit 0 of a new word; the aborted word gets no out_last.
//  Overflow: for lanes with neg_q=1, ovf = 1 at bit WIDTH-1 if a=1 and seen=0, i.e. the input was -2^(WIDTH-1).
//   - The result equals the input in that case (0x80 -> 0x80 for WIDTH=8).
//   - Lanes with neg_q=0 never flag ovf.
//  Special inputs: an input of 0 with neg yields 0 and ovf=0.
//  bit_cnt width is clog2(WIDTH); no wrap beyond WIDTH-1, since the last bit always returns the block to IDLE.
//  Back-to-back words: a start on the cycle after the last bit is legal, with no bubble required.
//  in_valid=0: no state change; out_valid=0; out_bits/out_first/out_last/ovf = 0.
//  Reset mid-word: the word is discarded with no out_last and no frame_err; the next bit must carry start.
// STRUCTURE
//  Package spm_pkg:
//   - state encoding localparams ST_IDLE/ST_RUN
//   - clog2 function
//   - default SPM_WIDTH=8
//  Sub-module serial_neg_lane, instantiated CHANNELS times, one per lane:
//   - holds seen, neg_q and the output flop
//   - computes r and ovf
//   - inputs: bit, first, last, valid
//  Top level holds the FSM, bit_cnt, and the out_valid/out_first/out_last/frame_err flops.
// TESTING (WIDTH=8 unless noted; bit streams are LSB first)
//  1. Send 0x05 with neg=1, no gaps -> output 0xFB; out_first on the 1st output, out_last on the 8th; ovf=0.
//  2. Send 0x3C with neg=0 -> output 0x3C. Then, back-to-back, send 0x80 with neg=1 -> output 0x80 with ovf=1 on out_last.
//  3. Send 0x12 with neg=1 and random in_valid gaps -> output 0xEE; out_valid tracks in_valid exactly 1 cycle late.
//  4. Abort: start, then 3 bits, then start with 0x01 and neg=1 -> frame_err pulses once; no out_last for the aborted word; next word output 0xFF.
//  5. Stray bit while IDLE, and rst=0 after 4 bits of a word:
//     - stray bit -> frame_err pulse, no out_valid
//     - reset -> all outputs 0, busy=0, no frame_err
//  6. CHANNELS=2: lane0 0x00 with neg=1, lane1 0x7F with neg=1 -> outputs 0x00 and 0x81; ovf=00.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier datapath.
// Holds the FSM state encoding, the default serial word width and a
// constant-evaluable clog2 used to size bit counters.
package spm_pkg;

   localparam int SPM_WIDTH = 8;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   // Smallest r with 2**r >= value (returns 0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_neg_lane.sv
// One bit-serial LSB-first conditional negation lane.
// Copies bits up to and including the first 1, then inverts the rest
// when negation is selected for the current word.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   valid      the input bit is accepted this cycle
//   first      accepted bit is bit 0 of a new word (restarts seen/neg_q)
//   last       accepted bit is the sign bit of the word
//   neg        negate select, taken only with first
//   a_bit      serial input bit
//   r          registered result bit (0 when not valid)
//   ovf        registered overflow flag (only with last)
module serial_neg_lane (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   input  logic first,
   input  logic last,
   input  logic neg,
   input  logic a_bit,
   output logic r,
   output logic ovf
);

   logic seen_q, seen_d;
   logic neg_q, neg_d;
   logic r_q, r_d;
   logic ovf_q, ovf_d;
   logic eff_seen, eff_neg;

   // A start bit sees fresh per-word state, not the previous word's.
   assign eff_seen = first ? 1'b0 : seen_q;
   assign eff_neg  = first ? neg  : neg_q;

   always_comb begin
      seen_d = seen_q;
      neg_d  = neg_q;
      r_d    = 1'b0;
      ovf_d  = 1'b0;
      if (valid) begin
         r_d    = a_bit ^ (eff_neg & eff_seen);
         // Sign bit set with no earlier 1: input was the most negative value.
         ovf_d  = last & eff_neg & a_bit & ~eff_seen;
         seen_d = eff_seen | a_bit;
         neg_d  = eff_neg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         seen_q <= 1'b0;
         neg_q  <= 1'b0;
         r_q    <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         seen_q <= seen_d;
         neg_q  <= neg_d;
         r_q    <= r_d;
         ovf_q  <= ovf_d;
      end
   end

   assign r   = r_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/serial_negate_multi.sv
// Multi-lane bit-serial conditional two's-complement unit.
// All lanes share one word framing (in_valid/start); each lane negates
// or passes its word and flags negation overflow on the sign bit.
// Output is registered: a bit accepted at one edge is presented until the next.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   in_valid, start      input qualifier and word-start marker (bit 0)
//   neg[CHANNELS]        per-lane negate select, sampled on accepted start
//   a[CHANNELS]          per-lane serial input
//   out_valid/out_first/out_last   output framing
//   out_bits[CHANNELS]   per-lane serial result
//   ovf[CHANNELS]        per-lane overflow, only alongside out_last
//   busy                 word in progress
//   frame_err            pulse on aborted word or dropped stray bit
module serial_negate_multi
   import spm_pkg::*;
#(
   parameter int WIDTH    = SPM_WIDTH,
   parameter int CHANNELS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                start,
   input  logic [CHANNELS-1:0] neg,
   input  logic [CHANNELS-1:0] a,
   output logic                out_valid,
   output logic [CHANNELS-1:0] out_bits,
   output logic                out_first,
   output logic                out_last,
   output logic [CHANNELS-1:0] ovf,
   output logic                busy,
   output logic                frame_err
);

   localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   typedef enum logic {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             out_valid_q, out_first_q, out_last_q, frame_err_q;
   logic             accept, first, last, frame_err_d;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      accept      = 1'b0;
      first       = 1'b0;
      last        = 1'b0;
      frame_err_d = 1'b0;
      if (in_valid) begin
         if (start) begin
            // A start while RUN aborts the word in flight; the start bit
            // still opens a new word.
            accept      = 1'b1;
            first       = 1'b1;
            frame_err_d = (state_q == S_RUN);
            state_d     = S_RUN;
            bit_cnt_d   = CNT_W'(1);
         end else if (state_q == S_RUN) begin
            accept = 1'b1;
            if (bit_cnt_q == LAST_IDX) begin
               last      = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end else begin
            // Non-start bit with no word open: dropped.
            frame_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         out_valid_q <= accept;
         out_first_q <= first;
         out_last_q  <= last;
         frame_err_q <= frame_err_d;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      serial_neg_lane u_lane (
         .clk   (clk),
         .rst   (rst),
         .valid (accept),
         .first (first),
         .last  (last),
         .neg   (neg[c]),
         .a_bit (a[c]),
         .r     (out_bits[c]),
         .ovf   (ovf[c])
      );
   end

   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_serial_negate_multi.sv
// Randomised self-checking bench for serial_negate_multi (WIDTH=8, CHANNELS=2).
// Expected output words are computed arithmetically (-x mod 2^W) per word.
module tb_serial_negate_multi;

   localparam int W  = 8;
   localparam int CH = 2;
   localparam logic [W-1:0] MINV = W'(1) << (W - 1);

   logic          clk = 1'b0;
   logic          rst, in_valid, start;
   logic [CH-1:0] neg, a;
   logic          out_valid, out_first, out_last, busy, frame_err;
   logic [CH-1:0] out_bits, ovf;

   int n_vec = 0;
   int n_err = 0;
   bit in_word = 1'b0;

   logic [CH-1:0][W-1:0] cap;
   logic [CH-1:0]        last_ovf;
   int                   cap_idx = 0;

   serial_negate_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .start(start), .neg(neg), .a(a),
      .out_valid(out_valid), .out_bits(out_bits), .out_first(out_first),
      .out_last(out_last), .ovf(ovf), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of inputs and check the registered outputs after the edge.
   task automatic cyc(input logic r, input logic iv, input logic st,
                      input logic [CH-1:0] ng, input logic [CH-1:0] av,
                      input logic ev, input logic [CH-1:0] eb, input logic ef,
                      input logic el, input logic [CH-1:0] eo, input logic efe,
                      input logic eby);
      rst = r; in_valid = iv; start = st; neg = ng; a = av;
      @(posedge clk); #1;
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_bits",  32'(out_bits),  32'(eb));
      chk("out_first", 32'(out_first), 32'(ef));
      chk("out_last",  32'(out_last),  32'(el));
      chk("ovf",       32'(ovf),       32'(eo));
      chk("frame_err", 32'(frame_err), 32'(efe));
      chk("busy",      32'(busy),      32'(eby));
      if (out_valid) begin
         if (out_first) cap_idx = 0;
         if (cap_idx < W) begin
            for (int c = 0; c < CH; c++) cap[c][cap_idx] = out_bits[c];
         end
         cap_idx++;
         if (out_last) last_ovf = ovf;
      end
   endtask

   task automatic gap();
      logic [CH-1:0] rn, ra;
      logic rs;
      rn = CH'($urandom); ra = CH'($urandom); rs = 1'($urandom);
      cyc(1'b1, 1'b0, rs, rn, ra, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, in_word);
   endtask

   task automatic stray();
      logic [CH-1:0] rn, ra;
      rn = CH'($urandom); ra = CH'($urandom);
      cyc(1'b1, 1'b1, 1'b0, rn, ra, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      logic [CH-1:0] rn, ra;
      logic riv, rs;
      rn = CH'($urandom); ra = CH'($urandom); riv = 1'($urandom); rs = 1'($urandom);
      cyc(1'b0, riv, rs, rn, ra, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      in_word = 1'b0;
   endtask

   // Send the first nbits of a word; expectations come from the word-level result.
   task automatic send_word(input logic [CH-1:0][W-1:0] val, input logic [CH-1:0] ng,
                            input int nbits, input int gap_pct);
      logic [CH-1:0][W-1:0] res;
      logic [CH-1:0] ov, av, eb, eo, ndrv;
      logic fst, lst, fe;
      for (int c = 0; c < CH; c++) begin
         res[c] = ng[c] ? (W'(0) - val[c]) : val[c];
         ov[c]  = ng[c] && (val[c] == MINV);
      end
      for (int i = 0; i < nbits; i++) begin
         for (int g = 0; g < 3; g++) begin
            if (i != 0 && int'($urandom_range(99)) < gap_pct) gap();
         end
         for (int c = 0; c < CH; c++) begin
            av[c] = val[c][i];
            eb[c] = res[c][i];
         end
         fst  = (i == 0);
         lst  = (i == W - 1);
         fe   = fst && in_word;
         eo   = lst ? ov : '0;
         // neg must be ignored on non-start bits, so scramble it there.
         ndrv = fst ? ng : CH'($urandom);
         cyc(1'b1, 1'b1, fst, ndrv, av, 1'b1, eb, fst, lst, eo, fe, !lst);
         in_word = !lst;
      end
   endtask

   initial begin
      logic [CH-1:0][W-1:0] v;
      logic [CH-1:0] n;
      // reset state
      do_reset();
      do_reset();

      // 1: 0x05 negated -> 0xFB
      send_word({8'h05, 8'h05}, 2'b11, W, 0);
      chk("t1_word", 32'(cap), 32'({8'hFB, 8'hFB}));
      chk("t1_ovf", 32'(last_ovf), 32'(2'b00));

      // 2: pass 0x3C, then back-to-back 0x80 negated -> 0x80 with ovf
      send_word({8'h3C, 8'h3C}, 2'b00, W, 0);
      chk("t2a_word", 32'(cap), 32'({8'h3C, 8'h3C}));
      send_word({8'h80, 8'h80}, 2'b11, W, 0);
      chk("t2b_word", 32'(cap), 32'({8'h80, 8'h80}));
      chk("t2b_ovf", 32'(last_ovf), 32'(2'b11));

      // 3: 0x12 negated with gaps -> 0xEE
      send_word({8'h12, 8'h12}, 2'b11, W, 50);
      chk("t3_word", 32'(cap), 32'({8'hEE, 8'hEE}));

      // 4: abort after start+3 bits, then 0x01 negated -> 0xFF
      send_word({8'hA5, 8'h5A}, 2'b01, 4, 0);
      send_word({8'h01, 8'h01}, 2'b11, W, 0);
      chk("t4_word", 32'(cap), 32'({8'hFF, 8'hFF}));

      // 5: stray bit while idle; reset after 4 bits; stray after reset
      stray();
      send_word({8'hC3, 8'h3C}, 2'b10, 4, 0);
      do_reset();
      stray();

      // 6: lane0 0x00, lane1 0x7F, both negated -> 0x00 / 0x81, no ovf
      send_word({8'h7F, 8'h00}, 2'b11, W, 0);
      chk("t6_word", 32'(cap), 32'({8'h81, 8'h00}));
      chk("t6_ovf", 32'(last_ovf), 32'(2'b00));

      // randomised traffic
      for (int k = 0; k < 300; k++) begin
         for (int c = 0; c < CH; c++) begin
            case ($urandom_range(7))
               0: v[c] = MINV;
               1: v[c] = '0;
               default: v[c] = W'($urandom);
            endcase
         end
         n = CH'($urandom);
         case ($urandom_range(9))
            0: if (!in_word) stray(); else gap();
            1: send_word(v, n, int'($urandom_range(W - 1, 1)), 20);
            2: do_reset();
            3: gap();
            default: send_word(v, n, W, 20);
         endcase
      end
      send_word({8'h80, 8'h80}, 2'b01, W, 0);
      chk("final_ovf", 32'(last_ovf), 32'(2'b01));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
